// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with locked grants and back-to-back handoff.
// Define RR_ARB_HOLD_LIMIT_EN to cap each grant at MAX_HOLD cycles.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] id_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] arb_ptr;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic           rel;
  logic           limit_hit;
  logic [2*N-1:0] dbl;

  assign nxt_ptr = (gnt_id == IDW'(N - 1)) ? '0
                 : gnt_id + IDW'(1);

  // A release arbitrates with the rotated pointer in the same cycle
  assign arb_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;

  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N; i++) begin
      if (i < int'(arb_ptr)) dbl[i] = 1'b0;
    end
    win     = '0;
    win_vld = |req;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) win = IDW'(i % N);
    end
  end

  assign rel = done | ~req[gnt_id] | limit_hit;

`ifdef RR_ARB_HOLD_LIMIT_EN
  logic [7:0] cnt_q;

  assign limit_hit = gnt_vld
                   & (cnt_q == 8'(MAX_HOLD - 1))
                   & ~done & req[gnt_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      preempt <= 1'b0;
    end else begin
      cnt_q   <= (gnt_vld && !rel) ? cnt_q + 8'd1 : 8'd0;
      preempt <= limit_hit;
    end
  end
`else
  assign limit_hit = 1'b0;
  assign preempt   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d    = GRANT;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          id_d       = win;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = nxt_ptr;
          if (win_vld) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            id_d       = win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_vld = (state_q == GRANT);

endmodule
